// File: rtl/serial_to_parallel_pkg.sv
// Shared definitions for the serial frame receiver: FSM states and default frame geometry.
package serial_to_parallel_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_e;

  localparam int DEF_DATA_BITS = 8;
  localparam int DEF_STOP_BITS = 2;
  localparam int DEF_FRAME_W   = DEF_DATA_BITS + DEF_STOP_BITS;
  localparam int DEF_CNT_W     = $clog2(DEF_FRAME_W + 1);

endpackage

// File: rtl/serial_to_parallel.sv
// Idle-high serial frame receiver: detects a start bit, shifts in data plus stop bits
// MSB-first and presents the completed frame as a held parallel word with a valid pulse.
module serial_to_parallel
  import serial_to_parallel_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int STOP_BITS = DEF_STOP_BITS
) (
  input  logic                           Clock,
  input  logic                           iReset,
  input  logic                           i1b,
  output logic [DATA_BITS+STOP_BITS-1:0] o11b,
  output logic                           oValid,
  output logic                           oFrameErr
);

  localparam int W    = DATA_BITS + STOP_BITS;
  localparam int CntW = $clog2(W + 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    shift_q, shift_d;
  logic [W-1:0]    word_q, word_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic [W-1:0]    shiftNext;

  assign shiftNext = {shift_q[W-2:0], i1b};

  always_ff @(posedge Clock or negedge iReset) begin
    if (!iReset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // The counter holds the number of bits already shifted, so bit W arrives when it reads W-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    word_d  = word_q;
    valid_d = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (!i1b) begin
          state_d = RECV;
          cnt_d   = '0;
        end
      end
      RECV: begin
        shift_d = shiftNext;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntW'(W - 1)) begin
          word_d  = shiftNext;
          valid_d = 1'b1;
          err_d   = ~&shiftNext[STOP_BITS-1:0];
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o11b      = word_q;
  assign oValid    = valid_q;
  assign oFrameErr = err_q;

endmodule

// File: tb/tb_serial_to_parallel.sv
// Self-checking bench: a frame-level reference model compared every cycle, plus literal checks.
module tb_serial_to_parallel;
  import serial_to_parallel_pkg::*;

  localparam int W  = DEF_FRAME_W;
  localparam int SB = DEF_STOP_BITS;

  logic         Clock = 1'b0;
  logic         iReset = 1'b0;
  logic         i1b = 1'b1;
  logic [W-1:0] o11b;
  logic         oValid;
  logic         oFrameErr;

  int compared = 0;
  int mismatched = 0;
  int cycle = 0;
  int validCount = 0;
  int validCycles[$];

  // reference model: frame-level view of the line
  logic         mBusy;
  int           mBits;
  int           mAcc;
  logic [W-1:0] mWord;
  logic         mValid;
  logic         mErr;

  serial_to_parallel dut (
    .Clock    (Clock),
    .iReset   (iReset),
    .i1b      (i1b),
    .o11b     (o11b),
    .oValid   (oValid),
    .oFrameErr(oFrameErr)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) cycle <= cycle + 1;

  // The model accumulates a frame as an integer, weighting earlier bits more heavily.
  always @(posedge Clock or negedge iReset) begin : model
    int acc;
    if (!iReset) begin
      mBusy  <= 1'b0;
      mBits  <= 0;
      mAcc   <= 0;
      mWord  <= '0;
      mValid <= 1'b0;
      mErr   <= 1'b0;
    end else begin
      mValid <= 1'b0;
      if (!mBusy) begin
        if (i1b == 1'b0) begin
          mBusy <= 1'b1;
          mBits <= 0;
          mAcc  <= 0;
        end
      end else begin
        acc = mAcc * 2 + int'(i1b);
        if (mBits + 1 == W) begin
          mWord  <= acc[W-1:0];
          mValid <= 1'b1;
          mErr   <= (acc % (1 << SB)) != ((1 << SB) - 1);
          mBusy  <= 1'b0;
        end else begin
          mAcc  <= acc;
          mBits <= mBits + 1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Every negedge the DUT outputs must equal the model.
  always @(negedge Clock) begin
    checkOutput("model.o11b", 32'(o11b), 32'(mWord));
    checkOutput("model.oValid", 32'(oValid), 32'(mValid));
    checkOutput("model.oFrameErr", 32'(oFrameErr), 32'(mErr));
    if (oValid === 1'b1) begin
      validCount++;
      validCycles.push_back(cycle);
    end
  end

  task automatic applyStimulus(input logic [W:0] frame);
    for (int i = W; i >= 0; i--) begin
      @(negedge Clock);
      i1b = frame[i];
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge Clock);
      i1b = 1'b1;
    end
  endtask

  task automatic afterEdge();
    @(posedge Clock);
    #1;
  endtask

  localparam logic [W:0] FRAME_A   = 11'b0_1101000111;
  localparam logic [W:0] FRAME_B   = 11'b0_1111000011;
  localparam logic [W:0] FRAME_C   = 11'b0_1000011011;
  localparam logic [W:0] FRAME_ERR = 11'b0_1010101010;

  initial begin
    int vBefore;
    logic [W:0] partA;

    // reset then idle
    iReset = 1'b0;
    i1b = 1'b1;
    repeat (2) @(negedge Clock);
    checkOutput("reset.o11b", 32'(o11b), 32'h0);
    checkOutput("reset.oValid", 32'(oValid), 32'h0);
    iReset = 1'b1;
    idle(20);
    checkOutput("idle.o11b", 32'(o11b), 32'h0);
    checkOutput("idle.oFrameErr", 32'(oFrameErr), 32'h0);
    checkOutput("idle.validCount", 32'(validCount), 32'h0);

    // frame A
    applyStimulus(FRAME_A);
    afterEdge();
    checkOutput("A.o11b", 32'(o11b), 32'h347);
    checkOutput("A.oValid", 32'(oValid), 32'h1);
    checkOutput("A.oFrameErr", 32'(oFrameErr), 32'h0);
    afterEdge();
    checkOutput("A.validFalls", 32'(oValid), 32'h0);
    idle(3);
    checkOutput("A.hold", 32'(o11b), 32'h347);

    applyStimulus(FRAME_B);
    afterEdge();
    checkOutput("B.o11b", 32'(o11b), 32'h3C3);
    idle(4);
    checkOutput("B.hold", 32'(o11b), 32'h3C3);

    applyStimulus(FRAME_C);
    afterEdge();
    checkOutput("C.o11b", 32'(o11b), 32'h21B);
    idle(4);
    checkOutput("C.hold", 32'(o11b), 32'h21B);

    // framing error, then a good frame clears the flag
    applyStimulus(FRAME_ERR);
    afterEdge();
    checkOutput("err.o11b", 32'(o11b), 32'h2AA);
    checkOutput("err.oFrameErr", 32'(oFrameErr), 32'h1);
    checkOutput("err.oValid", 32'(oValid), 32'h1);
    idle(4);
    checkOutput("err.held", 32'(oFrameErr), 32'h1);
    applyStimulus(FRAME_A);
    afterEdge();
    checkOutput("errClear.oFrameErr", 32'(oFrameErr), 32'h0);
    idle(4);

    // back-to-back A then B with no idle cycle
    vBefore = validCount;
    applyStimulus(FRAME_A);
    applyStimulus(FRAME_B);
    afterEdge();
    checkOutput("b2b.o11b", 32'(o11b), 32'h3C3);
    idle(2);
    checkOutput("b2b.pulses", 32'(validCount - vBefore), 32'd2);
    if (validCycles.size() >= 2)
      checkOutput("b2b.spacing", 32'(validCycles[$] - validCycles[$-1]), 32'd11);
    else
      checkOutput("b2b.spacingAvail", 32'(validCycles.size()), 32'd2);

    // reset mid-frame discards the partial frame
    partA = FRAME_A;
    for (int i = W; i > W - 5; i--) begin
      @(negedge Clock);
      i1b = partA[i];
    end
    @(negedge Clock);
    iReset = 1'b0;
    i1b = 1'b1;
    #1;
    checkOutput("midReset.o11b", 32'(o11b), 32'h0);
    checkOutput("midReset.oValid", 32'(oValid), 32'h0);
    vBefore = validCount;
    repeat (2) @(negedge Clock);
    iReset = 1'b1;
    idle(12);
    checkOutput("midReset.noValid", 32'(validCount - vBefore), 32'h0);
    checkOutput("midReset.o11bAfter", 32'(o11b), 32'h0);
    applyStimulus(FRAME_C);
    afterEdge();
    checkOutput("midReset.C", 32'(o11b), 32'h21B);
    checkOutput("midReset.CValid", 32'(oValid), 32'h1);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
